doppler_peak_detector: RTL and testbench
========================================

# doppler_peak_detector

Consumes one 16-bin Doppler spectrum (real/imag) from the Doppler FFT stage, computes an approximate magnitude per bin, scans serially for the strongest bin, and reports peak bin, signed velocity index and peak magnitude to the velocity processor back end. It is the stage directly downstream of the Doppler FFT. It accepts one spectrum at a time under a valid/ready handshake and holds its result until the consumer accepts it.

## Interface
- DATA_W, 16: width of signed real/imag input samples.
- NUM_BINS, 16: Doppler bins per spectrum; fixed at 16 (4-bit index).
- GATE_SHIFT, 1: noise-gate multiplier exponent (threshold = mean << GATE_SHIFT); used only with the gate compiled in.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  spectrum on doppler_real/doppler_imag is valid.
- in_ready  out  1  block can accept a spectrum.
- doppler_real  in  DATA_W x [0:15]  signed real parts.
- doppler_imag  in  DATA_W x [0:15]  signed imaginary parts.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- peak_bin  out  4  index of the strongest bin.
- peak_vel  out  5  signed velocity index (fftshifted bin).
- peak_mag  out  DATA_W+1  approximate magnitude of the peak.
- detect  out  1  peak qualifies as a target.

## Operation
- States: IDLE, SCAN, HOLD.
- IDLE: in_ready=1. On in_valid&&in_ready, latch all 32 samples into an internal buffer, clear the running max, index and sum, and go to SCAN.
- SCAN: one bin per cycle, idx 0..15. mag = max(|re|,|im|) + (min(|re|,|im|) >> 1). All values are unsigned DATA_W+1. |-32768| = 32768, with no saturation. Update the max only if mag > current max (strict), so on ties the lowest index wins. Accumulate the sum (DATA_W+5 bits). After idx 15, register the outputs and go to HOLD.
- HOLD: out_valid=1 and the outputs are stable. On out_ready, go to IDLE. out_valid drops on the next cycle.
- peak_vel = sign-extension of peak_bin read as 4-bit two's complement: bins 0..7 give +0..+7, bins 8..15 give -8..-1.
- detect = (peak_mag != 0), further qualified by the gate if it is compiled in.
- An all-zero spectrum gives peak_bin=0, peak_mag=0, detect=0.
- in_ready=0 in SCAN and HOLD. Input changes there are ignored.

## Timing
- Reset values: in_ready=0 during reset, 1 in the first cycle after release. out_valid=0, peak_bin=0, peak_vel=0, peak_mag=0, detect=0. State=IDLE.
- Accept at cycle T. SCAN occupies T+1..T+16. out_valid is high from T+17.
- out_ready already high at T+17: the result is accepted that cycle. in_ready=1 at T+18, giving a minimum spacing of 18 cycles per spectrum.
- out_ready low: outputs hold indefinitely without change.
- Reset asserted mid-SCAN or mid-HOLD: immediate return to IDLE with all outputs at reset values. The partial result is discarded.
- Outputs are registered only. There is no combinational path from in_* to out_*.

## Configuration
- DOPPLER_NOISE_GATE_EN defined: mean = sum >> 4 (mean includes the peak). detect = (peak_mag != 0) && (peak_mag > (mean << GATE_SHIFT)). Latency is unchanged.
- Not defined: no sum accumulator is built, and detect = (peak_mag != 0). GATE_SHIFT is unused.

## Structure
- Shared package radar_doppler_pkg holds:
  - DATA_W, NUM_BINS and MAG_W = DATA_W+1.
  - The state_t enum {IDLE, SCAN, HOLD}.
  - The bin-to-velocity conversion function.
- One combinational sub-module, cplx_mag_approx (re, im in; mag out), instantiated once on the scan path.

## Test plan
- Single tone: bin 5 re=1000, im=0, all other bins 0 -> peak_bin=5, peak_vel=+5, peak_mag=1000, detect=1, out_valid at T+17.
- Negative velocity: bin 12 re=-300, im=400, others 0 -> mag=400+150=550, peak_bin=12, peak_vel=-4.
- Tie and extreme values: bins 3 and 9 both re=-32768, im=-32768 -> mag=49152, peak_bin=3 (lowest index wins).
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and new data -> outputs stable, in_ready=0, second spectrum accepted only after the out_ready handshake.
- Noise gate (DOPPLER_NOISE_GATE_EN, GATE_SHIFT=1): all 16 bins re=100 -> mean=100, peak=100, detect=0. Then bin 2 re=400, rest re=100 -> sum=1900, mean=118, detect=1.
- Reset at T+8 mid-SCAN -> out_valid stays 0, all outputs 0, in_ready=1 after release; the next spectrum produces a correct result.

Source files
------------

// File: rtl/radar_doppler_pkg.sv
// rtl/radar_doppler_pkg.sv - shared constants, FSM state type and bin-to-velocity helper
package radar_doppler_pkg;

   localparam int DATA_W     = 16;
   localparam int NUM_BINS   = 16;
   localparam int MAG_W      = DATA_W + 1;
   localparam int SUM_W      = DATA_W + 5;
   localparam int GATE_SHIFT = 1;

   typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

   // fftshift view: bins 8..15 are the negative velocities -8..-1
   function automatic logic signed [4:0] bin_to_vel(input logic [3:0] bin);
      return {bin[3], bin};
   endfunction

endpackage

// File: rtl/cplx_mag_approx.sv
// rtl/cplx_mag_approx.sv - alpha-max-plus-beta-min magnitude, max + min/2, no saturation
module cplx_mag_approx
   import radar_doppler_pkg::*;
(
   input  logic signed [DATA_W-1:0] re,
   input  logic signed [DATA_W-1:0] im,
   output logic        [MAG_W-1:0]  mag
);

   logic signed [MAG_W-1:0] re_x, im_x;
   logic        [MAG_W-1:0] abs_re, abs_im, hi, lo;

   // one extra bit so that |-32768| is representable
   assign re_x   = MAG_W'(re);
   assign im_x   = MAG_W'(im);
   assign abs_re = re_x[MAG_W-1] ? MAG_W'(-re_x) : MAG_W'(re_x);
   assign abs_im = im_x[MAG_W-1] ? MAG_W'(-im_x) : MAG_W'(im_x);
   assign hi     = (abs_re > abs_im) ? abs_re : abs_im;
   assign lo     = (abs_re > abs_im) ? abs_im : abs_re;
   assign mag    = hi + (lo >> 1);

endmodule

// File: rtl/doppler_peak_detector.sv
// rtl/doppler_peak_detector.sv - serial peak search over one 16-bin Doppler spectrum
// Optional mean-based noise gate on detect: define DOPPLER_NOISE_GATE_EN.
module doppler_peak_detector
   import radar_doppler_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] doppler_real [0:NUM_BINS-1],
   input  logic signed [DATA_W-1:0] doppler_imag [0:NUM_BINS-1],
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               peak_bin,
   output logic signed [4:0]        peak_vel,
   output logic [MAG_W-1:0]         peak_mag,
   output logic                     detect
);

   logic signed [DATA_W-1:0] re_buf [0:NUM_BINS-1];
   logic signed [DATA_W-1:0] im_buf [0:NUM_BINS-1];
   state_t                   state;
   logic [3:0]               idx, max_idx, best_idx;
   logic [MAG_W-1:0]         mag, max_mag, best_mag;
   logic                     accept, det_next;

   assign accept = (state == IDLE) && in_ready && in_valid;

   always_ff @(posedge clk) begin
      if (accept) begin
         re_buf <= doppler_real;
         im_buf <= doppler_imag;
      end
   end

   cplx_mag_approx u_mag (
      .re  (re_buf[idx]),
      .im  (im_buf[idx]),
      .mag (mag)
   );

   // strict compare keeps the lowest index on ties
   assign best_mag = (mag > max_mag) ? mag : max_mag;
   assign best_idx = (mag > max_mag) ? idx : max_idx;

`ifdef DOPPLER_NOISE_GATE_EN
   localparam int THR_W = SUM_W + GATE_SHIFT;
   logic [SUM_W-1:0] sum, sum_next;
   logic [THR_W-1:0] thresh;

   assign sum_next = sum + SUM_W'(mag);
   assign thresh   = THR_W'(sum_next >> 4) << GATE_SHIFT;
   assign det_next = (best_mag != '0) && (THR_W'(best_mag) > thresh);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)               sum <= '0;
      else if (accept)         sum <= '0;
      else if (state == SCAN)  sum <= sum_next;
   end
`else
   assign det_next = (best_mag != '0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         idx       <= '0;
         max_idx   <= '0;
         max_mag   <= '0;
         peak_bin  <= '0;
         peak_vel  <= '0;
         peak_mag  <= '0;
         detect    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  in_ready <= 1'b0;
                  idx      <= '0;
                  max_idx  <= '0;
                  max_mag  <= '0;
                  state    <= SCAN;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            SCAN: begin
               max_mag <= best_mag;
               max_idx <= best_idx;
               idx     <= idx + 4'd1;
               if (idx == 4'(NUM_BINS - 1)) begin
                  peak_bin  <= best_idx;
                  peak_vel  <= bin_to_vel(best_idx);
                  peak_mag  <= best_mag;
                  detect    <= det_next;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_doppler_peak_detector.sv
// tb/tb_doppler_peak_detector.sv - directed and random spectra against an arithmetic reference model
module tb_doppler_peak_detector;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic               out_ready = 1'b0;
   logic               in_ready, out_valid, detect;
   logic signed [15:0] d_re [0:15];
   logic signed [15:0] d_im [0:15];
   logic [3:0]         peak_bin;
   logic signed [4:0]  peak_vel;
   logic [16:0]        peak_mag;

   int checks = 0;
   int errors = 0;
   int m_re [16];
   int m_im [16];
   int exp_bin, exp_vel, exp_mag;
   int exp_det;

   always #5 clk = ~clk;

   doppler_peak_detector dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .doppler_real (d_re),
      .doppler_imag (d_im),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .peak_bin     (peak_bin),
      .peak_vel     (peak_vel),
      .peak_mag     (peak_mag),
      .detect       (detect)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: magnitude per bin, first strict maximum, optional mean gate (shift 1 = x2)
   function automatic void model();
      int best, sum, a, b, mag;
      best = -1;
      sum  = 0;
      for (int i = 0; i < 16; i++) begin
         a   = (m_re[i] < 0) ? -m_re[i] : m_re[i];
         b   = (m_im[i] < 0) ? -m_im[i] : m_im[i];
         mag = ((a > b) ? a : b) + ((a > b) ? b : a) / 2;
         sum += mag;
         if (mag > best) begin
            best    = mag;
            exp_bin = i;
         end
      end
      exp_mag = best;
      exp_vel = (exp_bin < 8) ? exp_bin : exp_bin - 16;
      exp_det = (best != 0) ? 1 : 0;
`ifdef DOPPLER_NOISE_GATE_EN
      if (!(best > (sum / 16) * 2)) exp_det = 0;
`endif
   endfunction

   task automatic clear_in();
      for (int i = 0; i < 16; i++) begin
         d_re[i] = '0;
         d_im[i] = '0;
      end
   endtask

   task automatic scramble_in();
      for (int i = 0; i < 16; i++) begin
         d_re[i] = 16'($urandom);
         d_im[i] = 16'($urandom);
      end
   endtask

   task automatic check_result(input string tag);
      chk({tag, "_bin"}, peak_bin, exp_bin);
      chk({tag, "_vel"}, peak_vel, exp_vel);
      chk({tag, "_mag"}, peak_mag, exp_mag);
      chk({tag, "_det"}, detect, exp_det);
   endtask

   task automatic send(input string tag, input bit release_out);
      int n;
      for (int i = 0; i < 16; i++) begin
         m_re[i] = d_re[i];
         m_im[i] = d_im[i];
      end
      model();
      n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_ready_wait"}, (n < 40), 1);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      scramble_in();
      n = 1;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, 17);
      chk({tag, "_in_ready_hold"}, in_ready, 0);
      check_result(tag);
      if (release_out) begin
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk({tag, "_valid_drop"}, out_valid, 0);
         chk({tag, "_in_ready_back"}, in_ready, 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int v;
      clear_in();
      repeat (3) tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_bin", peak_bin, 0);
      chk("rst_vel", peak_vel, 0);
      chk("rst_mag", peak_mag, 0);
      chk("rst_det", detect, 0);
      reset = 1'b0;
      tick();
      chk("rel_in_ready", in_ready, 1);

      clear_in();
      d_re[5] = 16'sd1000;
      send("tone5", 1);
      chk("tone5_mag_abs", peak_mag, 1000);

      clear_in();
      d_re[12] = -16'sd300;
      d_im[12] = 16'sd400;
      send("negvel", 1);
      chk("negvel_abs", peak_vel, -4);

      clear_in();
      d_re[3] = 16'sh8000; d_im[3] = 16'sh8000;
      d_re[9] = 16'sh8000; d_im[9] = 16'sh8000;
      send("tie", 1);
      chk("tie_abs_mag", peak_mag, 49152);
      chk("tie_abs_bin", peak_bin, 3);

      clear_in();
      send("zero", 1);

      // backpressure: new data offered while the result is held
      scramble_in();
      send("bp", 0);
      scramble_in();
      in_valid = 1'b1;
      repeat (10) begin
         tick();
         chk("bp_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         check_result("bp_hold");
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("bp_drop", out_valid, 0);
      chk("bp_ready", in_ready, 1);
      send("bp2", 1);

      // reset in the middle of a scan
      scramble_in();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (7) tick();
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_mag", peak_mag, 0);
      chk("mid_rst_bin", peak_bin, 0);
      chk("mid_rst_vel", peak_vel, 0);
      chk("mid_rst_det", detect, 0);
      chk("mid_rst_ready", in_ready, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("mid_rel_ready", in_ready, 1);
      chk("mid_rel_valid", out_valid, 0);
      scramble_in();
      send("after_rst", 1);

      for (int k = 0; k < 24; k++) begin
         case ($urandom_range(0, 2))
            0: scramble_in();
            1: for (int i = 0; i < 16; i++) begin
                  v = int'($urandom_range(0, 100)) - 50;
                  d_re[i] = 16'(v);
                  v = int'($urandom_range(0, 100)) - 50;
                  d_im[i] = 16'(v);
               end
            default: for (int i = 0; i < 16; i++) begin
                  d_re[i] = ($urandom_range(0, 4) == 0) ? 16'sh8000 : 16'sd0;
                  d_im[i] = ($urandom_range(0, 4) == 0) ? 16'sh7fff : 16'sd0;
               end
         endcase
         send("rand", 1);
      end

      for (int i = 0; i < 16; i++) begin
         d_re[i] = 16'sd100;
         d_im[i] = 16'sd0;
      end
      send("gate_flat", 1);
      d_re[2] = 16'sd400;
      send("gate_peak", 1);
      chk("gate_peak_det", detect, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
